// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 16-bit ADC: serves parallel samples MSB-first on MISO
// in response to CNV/SCK, which are oversampled and synchronized on the system clock.
module adc_spi_responder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic             cnv_i,
  input  logic             spi_clk_i,
  output logic             spi_miso_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             frame_err_o,
  output logic [15:0]      frame_count_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHIFT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cnv_sync, sck_sync;
  logic                   cnv_d, sck_d;
  logic                   cnv_rise, cnv_fall, sck_fall;

  logic [WIDTH-1:0] hold, shift, shift_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic             miso_n, done_n, err_n;
  logic [15:0]      count_n;

  // Edge pulses are registered so every action lands a fixed SYNC_STAGES+2 cycles
  // after the pin edge.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnv_sync <= '0;
      sck_sync <= '0;
      cnv_d    <= 1'b0;
      sck_d    <= 1'b0;
      cnv_rise <= 1'b0;
      cnv_fall <= 1'b0;
      sck_fall <= 1'b0;
    end else begin
      cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], cnv_i};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      cnv_d    <= cnv_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
      cnv_rise <= cnv_sync[SYNC_STAGES-1] & ~cnv_d;
      cnv_fall <= ~cnv_sync[SYNC_STAGES-1] & cnv_d;
      sck_fall <= ~sck_sync[SYNC_STAGES-1] & sck_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hold <= '0;
    end else if (sample_valid_i) begin
      hold <= sample_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      spi_miso_o    <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      frame_count_o <= '0;
    end else begin
      state         <= state_n;
      shift         <= shift_n;
      bit_cnt       <= bit_cnt_n;
      spi_miso_o    <= miso_n;
      frame_done_o  <= done_n;
      frame_err_o   <= err_n;
      frame_count_o <= count_n;
    end
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    miso_n    = spi_miso_o;
    done_n    = 1'b0;
    err_n     = frame_err_o;
    count_n   = frame_count_o;

    if (cnv_rise) begin
      // A new CNV always restarts the frame; mid-frame it also flags an abort.
      shift_n   = sample_valid_i ? sample_i : hold;
      bit_cnt_n = '0;
      miso_n    = 1'b0;
      state_n   = CONVERT;
      if (state != IDLE) err_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        CONVERT: begin
          miso_n = 1'b0;
          if (cnv_fall) begin
            miso_n  = shift[WIDTH-1];
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (sck_fall) begin
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == CW'(WIDTH - 1)) begin
              state_n = IDLE;
              miso_n  = 1'b0;
              done_n  = 1'b1;
              count_n = frame_count_o + 16'd1;
            end else begin
              shift_n = {shift[WIDTH-2:0], 1'b0};
              miso_n  = shift[WIDTH-2];
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI responder that emulates the external 16-bit ADC on the far end of the ADC read interface: CNV/SCK in, MISO out.
- Serves a loopback test source, and a known stimulus, to the ADC reader and downstream CIC/FIR chain without analog hardware.
- Samples are supplied in parallel from fabric and shifted out MSB-first in response to CNV and SCK, which are oversampled on the 50 MHz system clock.

Parameters:
- WIDTH, 16, sample width in bits and SCK falling edges per frame.
- SYNC_STAGES, 2, synchronizer flops on cnv_i and spi_clk_i (minimum 2).

Ports:
- clk_i  in  1  system clock, 50 MHz.
- reset_ni  in  1  asynchronous active-low reset.
- sample_i  in  WIDTH  signed sample to serve next.
- sample_valid_i  in  1  loads sample_i into the hold register.
- cnv_i  in  1  conversion start / frame strobe from the reader.
- spi_clk_i  in  1  SPI clock from the reader.
- spi_miso_o  out  1  serial data to the reader.
- busy_o  out  1  high from CNV rise until frame end.
- frame_done_o  out  1  one-cycle pulse when the final bit has been shifted out.
- frame_err_o  out  1  sticky: frame aborted by a new CNV.
- frame_count_o  out  16  completed frames, wraps at 0xFFFF to 0.

Behaviour:
- Reset values (async assert, sync release):
  - state IDLE; spi_miso_o=0, busy_o=0, frame_done_o=0, frame_err_o=0, frame_count_o=0.
  - Hold register 0, shift register 0, bit counter 0.
  - Synchronizer flops 0.
- Input conditioning:
  - cnv_i and spi_clk_i each pass through SYNC_STAGES flops, plus one delay flop for edge detection.
  - Edges are taken on the synchronized versions only.
  - Legal SCK: high and low phases each ≥ SYNC_STAGES+2 clk_i cycles.
- Hold register: written from sample_i on any cycle with sample_valid_i=1, in any state.
- FSM states: IDLE, CONVERT, SHIFT.
- IDLE:
  - On synced CNV rising edge: shift register loads the hold register, or sample_i directly if sample_valid_i=1 that same cycle (bypass).
  - bit counter=0, busy_o=1, next state CONVERT.
  - SCK edges are ignored.
- CONVERT:
  - spi_miso_o=0; SCK edges are ignored.
  - On synced CNV falling edge: spi_miso_o is registered to shift[WIDTH-1], next state SHIFT.
- SHIFT (the reader samples MISO on SCK rising; the responder updates on SCK falling):
  - On synced SCK falling edge: bit counter increments.
  - If bit counter was below WIDTH-1: shift left by one and spi_miso_o = new MSB.
  - If bit counter was WIDTH-1: state IDLE, spi_miso_o=0, busy_o=0, frame_done_o=1 for one cycle, frame_count_o increments.
  - SCK rising edges have no effect.
- Latency: spi_miso_o updates exactly SYNC_STAGES+2 clk_i cycles after the raw pin edge (CNV fall or SCK fall). Verified at 4 cycles for the default.
- Abort: a synced CNV rising edge in SHIFT or CONVERT restarts the frame with the IDLE-rise actions. In addition:
  - frame_err_o is set (sticky until reset).
  - frame_count_o does not increment.
  - frame_done_o stays 0.
- Simultaneous events in the same cycle:
  - CNV rise and SCK fall: CNV rise wins.
  - sample_valid_i and CNV rise: the new sample is served.
- Reset mid-frame: all outputs return to reset values immediately; the partially shifted frame is discarded.
- Data: sample bits are transmitted unmodified (two's complement, MSB first). No conversion or offset is applied.

Test Plan:
- Reset, load 16'hA5C3, CNV pulse, then 16 SCK cycles at 1.5 MHz -> captured bits 1010_0101_1100_0011; frame_done_o pulses once; frame_count_o=1; busy_o falls with the done pulse.
- Back-to-back frames at 1 MHz with samples 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000 via the ADC reader -> reader data_o matches each; frame_count_o=4; frame_err_o=0.
- CNV re-asserted after 7 SCK falls of 16'h1234, then a full frame with hold value 16'h00FF -> frame_err_o=1; second frame reads 16'h00FF; frame_count_o=1.
- sample_valid_i pulsed with 16'hBEEF in the same cycle as the synced CNV rise (hold register = 16'h1111) -> frame serves 16'hBEEF.
- SCK toggled during IDLE and CONVERT before the CNV fall -> no miso change; frame still yields the loaded value.
- Assert reset_ni low after bit 9 of a frame -> outputs zero within the same cycle; next full frame after release reads the new hold value; frame_count_o restarts at 1.
